// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the writeback port arbiter: the queued LLU
// result record and the arbiter FSM state encoding.
package wb_arb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        EMPTY,
        QUEUED,
        FORCE
    } wb_arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle around the writeback port arbiter: pipeline W stage, LLU
// handshake, register-file write port, stall request and decode lookup.
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic              RegWriteW;
    logic [REG_AW-1:0] RdW;
    logic [XLEN-1:0]   ResultW;

    logic              lu_valid;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_data;
    logic              lu_ready;

    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [XLEN-1:0]   rf_wdata;

    logic              stall_req;

    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic [REG_AW-1:0] rdD;
    logic              pending_hit;

    modport slave (
        input  RegWriteW, RdW, ResultW,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output rf_we, rf_addr, rf_wdata,
        output stall_req,
        input  rs1D, rs2D, rdD,
        output pending_hit
    );

    modport master (
        output RegWriteW, RdW, ResultW,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  rf_we, rf_addr, rf_wdata,
        input  stall_req,
        output rs1D, rs2D, rdD,
        input  pending_hit
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry synchronous FIFO of LLU results with occupancy and a per-entry
// destination-register match vector for three lookup addresses.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_req_t                    din,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occ,
    input  logic [2:0][REG_AW-1:0]     qaddr,
    output logic [2:0][DEPTH-1:0]      qmatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    wb_req_t        mem [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic [AW-1:0]  off [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign occ   = wptr_q - rptr_q;
    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= din;
    end

    // An entry is live when its distance from the read pointer is below occupancy.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i]     = AW'(i) - rptr_q[AW-1:0];
            ent_vld[i] = ({1'b0, off[i]} < occ);
        end
    end

    always_comb begin
        qmatch = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                qmatch[k][i] = ent_vld[i] && (qaddr[k] != '0) && (mem[i].rd == qaddr[k]);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline W stage and queued
// LLU results. Define WBARB_STATS_EN to add stall/occupancy statistics outputs.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_port_arbiter_if.slave       bus
`ifdef WBARB_STATS_EN
    ,
    output logic [31:0]            stat_stall_cycles,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_arb_state_t          state_q;
    wb_arb_state_t          state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    logic                   full;
    logic                   empty;
    logic [OW-1:0]          occ;
    logic [OW-1:0]          occ_next;
    wb_req_t                head;
    wb_req_t                din;

    logic                   pipe_wr;
    logic                   xfer;
    logic                   push;
    logic                   pop;
    logic                   lu_hit;
    logic [2:0][REG_AW-1:0] qaddr;
    logic [2:0][DEPTH-1:0]  qmatch;

    // Every externally visible output is forced quiet while reset is held.
    assign bus.lu_ready = !reset && !full;
    assign xfer         = bus.lu_valid && bus.lu_ready;
    assign push         = xfer && (bus.lu_rd != '0);
    assign pipe_wr      = !reset && bus.RegWriteW && (bus.RdW != '0);
    assign pop          = !reset && !pipe_wr && !empty;
    assign occ_next     = occ + OW'(push) - OW'(pop);
    assign din          = wb_req_t'{rd: bus.lu_rd, data: bus.lu_data};

    wb_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .din    (din),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .occ    (occ),
        .qaddr  (qaddr),
        .qmatch (qmatch)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_addr  = '0;
        bus.rf_wdata = '0;
        if (pipe_wr) begin
            bus.rf_we    = 1'b1;
            bus.rf_addr  = bus.RdW;
            bus.rf_wdata = bus.ResultW;
        end else if (pop) begin
            bus.rf_we    = 1'b1;
            bus.rf_addr  = head.rd;
            bus.rf_wdata = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = QUEUED;
                    cnt_d   = '0;
                end
            end
            QUEUED: begin
                if (occ_next == '0) begin
                    state_d = EMPTY;
                    cnt_d   = '0;
                end else if (pop) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d >= CW'(STARVE_LIMIT - 1)) state_d = FORCE;
                end
            end
            FORCE: begin
                // Any pop, including one in the first FORCE cycle, ends the stall.
                if (pop) begin
                    cnt_d   = '0;
                    state_d = (occ_next == '0) ? EMPTY : QUEUED;
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.stall_req = !reset && (state_q == FORCE);

    assign qaddr = {bus.rdD, bus.rs2D, bus.rs1D};

    // The result still on the LLU bus is in flight and must be covered too.
    always_comb begin
        lu_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.lu_valid && (qaddr[k] != '0) && (qaddr[k] == bus.lu_rd)) lu_hit = 1'b1;
        end
    end

    assign bus.pending_hit = !reset && (lu_hit || (|qmatch));

`ifdef WBARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_cycles <= '0;
            stat_max_occ      <= '0;
        end else begin
            if (bus.stall_req && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            if (occ > stat_max_occ)
                stat_max_occ <= occ;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized plus directed bench for wb_port_arbiter against a queue-based
// reference model of the write-port sharing rules.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

`ifdef WBARB_STATS_EN
    logic [31:0]            stat_stall_cycles;
    logic [$clog2(DEPTH):0] stat_max_occ;
`endif

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WBARB_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_max_occ      (stat_max_occ)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending results in order, and how long the head has waited.
    wb_req_t mq[$];
    int      waitc      = 0;
    int      m_stall_cnt = 0;
    int      m_hw        = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_pipe_wr();
        return !reset && bus.RegWriteW && (bus.RdW != 5'd0);
    endfunction

    function automatic bit m_ready();
        return !reset && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_stall();
        return !reset && (mq.size() != 0) && (waitc >= LIMIT - 1);
    endfunction

    function automatic bit m_hit();
        logic [4:0] a [3];
        bit h;
        h = 0;
        if (reset) return 0;
        a[0] = bus.rs1D;
        a[1] = bus.rs2D;
        a[2] = bus.rdD;
        for (int k = 0; k < 3; k++) begin
            if (a[k] != 5'd0) begin
                for (int j = 0; j < mq.size(); j++)
                    if (mq[j].rd == a[k]) h = 1;
                if (bus.lu_valid && bus.lu_rd == a[k]) h = 1;
            end
        end
        return h;
    endfunction

    task automatic settle_check();
        logic        we;
        logic [4:0]  ad;
        logic [31:0] wd;
        #2;
        we = 1'b0;
        ad = '0;
        wd = '0;
        if (m_pipe_wr()) begin
            we = 1'b1; ad = bus.RdW; wd = bus.ResultW;
        end else if (!reset && mq.size() > 0) begin
            we = 1'b1; ad = mq[0].rd; wd = mq[0].data;
        end
        chk("rf_we",       32'(bus.rf_we),       32'(we));
        chk("rf_addr",     32'(bus.rf_addr),     32'(ad));
        chk("rf_wdata",    bus.rf_wdata,         wd);
        chk("lu_ready",    32'(bus.lu_ready),    32'(m_ready()));
        chk("stall_req",   32'(bus.stall_req),   32'(m_stall()));
        chk("pending_hit", 32'(bus.pending_hit), 32'(m_hit()));
`ifdef WBARB_STATS_EN
        chk("stat_stall",  stat_stall_cycles,    32'(m_stall_cnt));
        chk("stat_max_occ", 32'(stat_max_occ),   32'(m_hw));
`endif
    endtask

    task automatic tick();
        bit      pw, xfer, push, pop, was, stl;
        wb_req_t r;
        pw   = m_pipe_wr();
        xfer = bus.lu_valid && m_ready();
        push = xfer && (bus.lu_rd != 5'd0);
        was  = mq.size() > 0;
        pop  = !reset && !pw && was;
        stl  = m_stall();
        r.rd   = bus.lu_rd;
        r.data = bus.lu_data;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            waitc       = 0;
            m_stall_cnt = 0;
            m_hw        = 0;
        end else begin
            if (m_hw < mq.size()) m_hw = mq.size();
            if (stl) m_stall_cnt++;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(r);
            waitc = (pop || !was) ? 0 : waitc + 1;
        end
        #1;
        if (xfer) bus.lu_valid = 1'b0;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] data);
        bus.lu_valid = 1'b1;
        bus.lu_rd    = rd;
        bus.lu_data  = data;
    endtask

    initial begin
        reset         = 1'b1;
        bus.RegWriteW = 1'b0;
        bus.RdW       = '0;
        bus.ResultW   = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_data   = '0;
        bus.rs1D      = '0;
        bus.rs2D      = '0;
        bus.rdD       = '0;
        #1;
        step();
        step();
        reset = 1'b0;

        // Pipeline-only write
        bus.RegWriteW = 1'b1;
        bus.RdW       = 5'd5;
        bus.ResultW   = 32'h1234;
        settle_check();
        chk("pipe_we",    32'(bus.rf_we),     32'd1);
        chk("pipe_addr",  32'(bus.rf_addr),   32'd5);
        chk("pipe_data",  bus.rf_wdata,       32'h1234);
        chk("pipe_stall", 32'(bus.stall_req), 32'd0);
        tick();

        // Idle drain
        bus.RegWriteW = 1'b0;
        offer(5'd7, 32'hAAAA);
        step();
        settle_check();
        chk("drain_addr", 32'(bus.rf_addr), 32'd7);
        chk("drain_data", bus.rf_wdata,     32'hAAAA);
        tick();
        settle_check();
        chk("drain_after_we", 32'(bus.rf_we), 32'd0);
        tick();

        // Fill the FIFO behind continuous pipeline writes
        bus.RegWriteW = 1'b1;
        bus.RdW       = 5'd3;
        bus.ResultW   = 32'h3333;
        for (int i = 0; i < 4; i++) begin
            offer(5'(10 + i), 32'h100 + 32'(i));
            step();
        end
        offer(5'd14, 32'h114);
        settle_check();
        chk("full_ready", 32'(bus.lu_ready), 32'd0);
        tick();
        bus.RegWriteW = 1'b0;
        settle_check();
        chk("full_pop_addr", 32'(bus.rf_addr),  32'd10);
        chk("full_no_pass",  32'(bus.lu_ready), 32'd0);
        tick();
        settle_check();
        chk("fifth_ready", 32'(bus.lu_ready), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) step();

        // Starvation of a single queued entry
        bus.RegWriteW = 1'b1;
        bus.RdW       = 5'd3;
        bus.ResultW   = 32'h55;
        offer(5'd4, 32'h44);
        step();
        for (int k = 1; k <= 7; k++) begin
            settle_check();
            if (k == 7) chk("starve_c7", 32'(bus.stall_req), 32'd0);
            tick();
        end
        settle_check();
        chk("starve_c8", 32'(bus.stall_req), 32'd1);
        tick();
        bus.RegWriteW = 1'b0;
        settle_check();
        chk("starve_wr_addr", 32'(bus.rf_addr), 32'd4);
        tick();
        settle_check();
        chk("starve_release", 32'(bus.stall_req), 32'd0);
        tick();

        // Scoreboard lookups
        bus.RegWriteW = 1'b1;
        offer(5'd9, 32'h99);
        step();
        bus.rs2D = 5'd9;
        settle_check();
        chk("sb_rs2", 32'(bus.pending_hit), 32'd1);
        tick();
        bus.rs2D = 5'd0;
        bus.rs1D = 5'd0;
        offer(5'd0, 32'h0);
        settle_check();
        chk("sb_zero", 32'(bus.pending_hit), 32'd0);
        tick();
        bus.rdD = 5'd9;
        settle_check();
        chk("sb_rdD", 32'(bus.pending_hit), 32'd1);
        tick();
        bus.rdD       = 5'd0;
        bus.RegWriteW = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset while three entries are queued
        bus.RegWriteW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(5'(20 + i), 32'h200 + 32'(i));
            step();
        end
        reset = 1'b1;
        settle_check();
        chk("rst_we",    32'(bus.rf_we),    32'd0);
        chk("rst_ready", 32'(bus.lu_ready), 32'd0);
        tick();
        reset         = 1'b0;
        bus.RegWriteW = 1'b0;
        settle_check();
        chk("post_rst_we", 32'(bus.rf_we), 32'd0);
        tick();
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 63) == 0);
            bus.RegWriteW = ($urandom_range(0, 99) < 60);
            if (m_stall() && $urandom_range(0, 3) != 0) bus.RegWriteW = 1'b0;
            bus.RdW     = 5'($urandom_range(0, 31));
            bus.ResultW = $urandom;
            if (!bus.lu_valid && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 7) == 0) offer(5'd0, $urandom);
                else offer(5'($urandom_range(1, 15)), $urandom);
            end
            bus.rs1D = 5'($urandom_range(0, 15));
            bus.rs2D = 5'($urandom_range(0, 15));
            bus.rdD  = 5'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LLU, e.g. mul/div).
- The pipeline W stage always has priority. LLU results are queued in a small FIFO and drained into idle write-port cycles.
- A starvation timer requests a pipeline stall so that queued results are guaranteed to retire.
- A scoreboard lookup lets the hazard unit stall decode on RAW/WAW against queued results.

Parameters:
- DEPTH, 4, LLU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive non-draining cycles with FIFO non-empty before stall_req asserts (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWriteW  in  1  pipeline W stage write enable.
- RdW  in  5  pipeline W stage destination register.
- ResultW  in  32  pipeline W stage result.
- lu_valid  in  1  LLU result valid.
- lu_rd  in  5  LLU destination register.
- lu_data  in  32  LLU result data.
- lu_ready  out  1  arbiter can accept an LLU result this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req  out  1  to hazard unit: stall F/D/E and inject a W bubble.
- rs1D  in  5  decode source register 1.
- rs2D  in  5  decode source register 2.
- rdD  in  5  decode destination register.
- pending_hit  out  1  rs1D/rs2D/rdD (nonzero) matches a queued entry or the presented lu_rd.

Behaviour:
- **Reset:** FIFO empty, state EMPTY, starve counter 0, lu_ready 0, stall_req 0, pending_hit 0, rf_we 0, rf_addr 0, rf_wdata 0.
- **Handshake:** an LLU transfer occurs when lu_valid && lu_ready.
  - lu_ready = !full, registered-state only; there is no same-cycle pass-through when full, even if popping.
  - lu_valid/lu_rd/lu_data hold stable until the transfer.
- **rd == 0 from LLU:** the transfer is accepted and discarded, never enqueued.
- **Pipeline write:** pipe_wr = RegWriteW && RdW != 0.
  - When pipe_wr: rf_we=1, rf_addr=RdW, rf_wdata=ResultW, combinationally.
- **Drain:** when !pipe_wr && FIFO non-empty, the FIFO head drives rf_* with rf_we=1 and pops the same cycle.
  - Otherwise rf_we=0, rf_addr=0, rf_wdata=0.
- **Latency:** minimum 1 cycle from LLU transfer to rf write. No bypass from lu_* to rf_*.
- **Order:** strict FIFO.
- **Simultaneous push+pop:** allowed when not full; occupancy is unchanged.
- **States:**
  - EMPTY: occupancy 0. A push goes to QUEUED.
  - QUEUED: occupancy >0, stall_req=0.
    - Starve counter increments each cycle with no pop and clears on a pop.
    - When the counter reaches STARVE_LIMIT-1 without a pop, go to FORCE.
    - If occupancy reaches 0, go to EMPTY.
  - FORCE: stall_req=1 (registered).
    - Hazard unit zeroes RegWriteW from the next cycle, so a pop occurs.
    - After the first pop, go to QUEUED (counter cleared) or to EMPTY if now empty.
    - A pop in the entry cycle still counts.
- **pending_hit:** combinational. It ORs the comparisons of each of rs1D, rs2D, rdD (zero excluded) against valid FIFO entries and against lu_rd when lu_valid.
- **Reset mid-operation:** queued entries are dropped and no rf write occurs in the reset cycle.

Optional Feature:
- **WBARB_STATS_EN defined:** adds outputs stat_stall_cycles[31:0] and stat_max_occ[$clog2(DEPTH):0].
  - stat_stall_cycles counts cycles with stall_req=1 and saturates at all-ones.
  - stat_max_occ is the high-water occupancy.
  - Both clear on reset.
- **Undefined:** no such ports or logic exist.

Decomposition:
- **Package wb_arb_pkg:**
  - XLEN=32, REG_AW=5.
  - typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t.
  - typedef enum logic [1:0] {EMPTY, QUEUED, FORCE} wb_arb_state_t.
- **Sub-module wb_arb_fifo:** synchronous DEPTH-entry FIFO of wb_req_t with full/empty/occupancy and a per-entry rd-match vector for three query addresses.

Test Plan:
- **Pipeline only:** RegWriteW=1, RdW=5, ResultW=0x1234 with lu_valid=0 -> rf_we=1, rf_addr=5, rf_wdata=0x1234 same cycle; stall_req=0.
- **Idle drain:** LLU pushes rd=7/0xAAAA while RegWriteW=0 -> next cycle rf_we=1, rf_addr=7, rf_wdata=0xAAAA; FIFO empty after.
- **Full:** 4 LLU pushes while RegWriteW=1 every cycle -> lu_ready=0 in the cycle after the 4th push; a 5th lu_valid is held, not lost; it is accepted the cycle after the first pop.
- **Starvation:** one entry queued, RegWriteW=1/RdW=3 continuously -> stall_req=1 in cycle 8 after the push. After RegWriteW drops, the entry writes and stall_req=0 next cycle.
- **Scoreboard:**
  - Queued rd=9, rs2D=9 -> pending_hit=1.
  - rs1D=0 with lu_valid, lu_rd=0 -> pending_hit=0.
  - rdD=9 -> pending_hit=1.
- **Reset mid-queue:** 3 entries queued, reset high 1 cycle -> rf_we=0, lu_ready=0 that cycle; afterwards FIFO empty and no stale writes.
